// File: rtl/sum_acc_pkg.sv
// Shared types and default widths for the adder-sum accumulator.
// FSM encodings are plain localparams so legacy tools can consume them too.
package sum_acc_pkg;

   localparam int IN_W_DEF  = 5;
   localparam int ACC_W_DEF = 12;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = S_IDLE,
      ACCUM = S_ACCUM,
      HOLD  = S_HOLD
   } state_e;

endpackage

// File: rtl/rca_sum_accumulator_if.sv
// Sample-in / frame-total-out handshake bundle of the sum accumulator.
interface rca_sum_accumulator_if #(
   parameter int IN_W  = 5,
   parameter int ACC_W = 12
);
   logic [IN_W-1:0]  in_sum;
   logic             in_valid;
   logic             in_ready;
   logic [ACC_W-1:0] out_acc;
   logic             out_valid;
   logic             out_ready;
   logic             out_ovf;

   modport slave (
      input  in_sum, in_valid, out_ready,
      output in_ready, out_acc, out_valid, out_ovf
   );

   modport master (
      output in_sum, in_valid, out_ready,
      input  in_ready, out_acc, out_valid, out_ovf
   );
endinterface

// File: rtl/sum_acc_ctrl.sv
// Frame FSM and sample counter; emits load/accumulate/clear strobes to the datapath.
module sum_acc_ctrl
   import sum_acc_pkg::*;
#(
   parameter int NUM_SAMPLES = 8,
   parameter int CNT_W       = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid_i,
   input  logic out_ready_i,
   output logic in_ready_o,
   output logic out_valid_o,
   output logic busy_o,
   output logic load_o,
   output logic accum_o,
   output logic clear_o
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES - 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      load_o      = 1'b0;
      accum_o     = 1'b0;
      clear_o     = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready_o = 1'b1;
            if (in_valid_i) begin
               load_o  = 1'b1;
               cnt_d   = CNT_W'(1);
               state_d = S_ACCUM;
            end
         end
         S_ACCUM: begin
            in_ready_o = 1'b1;
            if (in_valid_i) begin
               accum_o = 1'b1;
               cnt_d   = cnt_q + 1'b1;
               // cnt counts samples already taken, so this edge takes the final one
               if (cnt_q == LAST_CNT) state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            out_valid_o = 1'b1;
            if (out_ready_i) begin
               clear_o = 1'b1;
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy_o = (state_q != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/rca_sum_accumulator.sv
// Accumulates NUM_SAMPLES adder sums per frame and hands out the total with an overflow flag.
// Build option SUM_ACC_SAT_EN: saturate the total at all-ones instead of wrapping.
module rca_sum_accumulator
   import sum_acc_pkg::*;
#(
   parameter int IN_W        = IN_W_DEF,
   parameter int ACC_W       = ACC_W_DEF,
   parameter int NUM_SAMPLES = 8,
   parameter int CNT_W       = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   rca_sum_accumulator_if.slave  bus,
   output logic                  busy
);

   logic             load, accum, clear;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic [ACC_W:0]   sum_w;
   logic             carry;

   sum_acc_ctrl #(
      .NUM_SAMPLES (NUM_SAMPLES),
      .CNT_W       (CNT_W)
   ) u_ctrl (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (bus.in_valid),
      .out_ready_i (bus.out_ready),
      .in_ready_o  (bus.in_ready),
      .out_valid_o (bus.out_valid),
      .busy_o      (busy),
      .load_o      (load),
      .accum_o     (accum),
      .clear_o     (clear)
   );

   assign sum_w = {1'b0, acc_q} + (ACC_W+1)'(bus.in_sum);
   assign carry = sum_w[ACC_W];

   // in_sum is only looked at under a strobe, so X on an idle bus never reaches state
   always_comb begin
      acc_d = acc_q;
      ovf_d = ovf_q;
      if (load) begin
         acc_d = ACC_W'(bus.in_sum);
         ovf_d = 1'b0;
      end else if (accum) begin
`ifdef SUM_ACC_SAT_EN
         acc_d = carry ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
`else
         acc_d = sum_w[ACC_W-1:0];
`endif
         ovf_d = ovf_q | carry;
      end else if (clear) begin
         acc_d = '0;
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         ovf_q <= ovf_d;
      end
   end

   assign bus.out_acc = acc_q;
   assign bus.out_ovf = ovf_q;

endmodule

// File: tb/tb_rca_sum_accumulator.sv
// Bench: a 12-bit and a 6-bit accumulator driven in lockstep, checked against frame totals.
module tb_rca_sum_accumulator;
   import sum_acc_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] in_sum;
   logic       in_valid;
   logic       out_ready;
   logic       busy12, busy6;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int unsigned frame_total = 0;
   int unsigned ft [3];
   logic [12:0] res12 [$];
   logic [12:0] res6 [$];

   rca_sum_accumulator_if #(.IN_W(5), .ACC_W(12)) bus12 ();
   rca_sum_accumulator_if #(.IN_W(5), .ACC_W(6))  bus6 ();

   assign bus12.in_sum    = in_sum;
   assign bus12.in_valid  = in_valid;
   assign bus12.out_ready = out_ready;
   assign bus6.in_sum     = in_sum;
   assign bus6.in_valid   = in_valid;
   assign bus6.out_ready  = out_ready;

   rca_sum_accumulator #(.IN_W(5), .ACC_W(12), .NUM_SAMPLES(8), .CNT_W(8)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus12),
      .busy (busy12)
   );

   rca_sum_accumulator #(.IN_W(5), .ACC_W(6), .NUM_SAMPLES(8), .CNT_W(8)) dut6 (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus6),
      .busy (busy6)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst && bus12.out_valid && bus12.out_ready)
         res12.push_back({bus12.out_ovf, bus12.out_acc});
      if (!rst && bus6.out_valid && bus6.out_ready)
         res6.push_back({bus6.out_ovf, 6'b0, bus6.out_acc});
   end

   // Frame result from the plain integer total: {ovf, acc}
   function automatic logic [12:0] model(input int unsigned total, input int w);
      int unsigned lim;
      logic        ov;
      int unsigned a;
      lim = 32'd1 << w;
      ov  = (total >= lim);
`ifdef SUM_ACC_SAT_EN
      a = ov ? lim - 1 : total;
`else
      a = total % lim;
`endif
      return {ov, 12'(a)};
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [4:0] s);
      int w;
      in_sum   = s;
      in_valid = 1'b1;
      w = 0;
      while (!bus12.in_ready && w < 50) begin
         tick();
         w++;
      end
      if (w >= 50) chk("in_ready_timeout", int'(bus12.in_ready), 1);
      tick();
      frame_total += s;
   endtask

   task automatic expect_frame(input string tag);
      logic [12:0] e, o;
      int w;
      w = 0;
      while ((res12.size() == 0 || res6.size() == 0) && w < 40) begin
         tick();
         w++;
      end
      chk({tag, "_seen"}, int'(res12.size() > 0 && res6.size() > 0), 1);
      if (res12.size() > 0) begin
         e = model(frame_total, 12);
         o = res12.pop_front();
         chk({tag, "_acc12"}, int'(o[11:0]), int'(e[11:0]));
         chk({tag, "_ovf12"}, int'(o[12]), int'(e[12]));
      end
      if (res6.size() > 0) begin
         e = model(frame_total, 6);
         o = res6.pop_front();
         chk({tag, "_acc6"}, int'(o[11:0]), int'(e[11:0]));
         chk({tag, "_ovf6"}, int'(o[12]), int'(e[12]));
      end
      frame_total = 0;
   endtask

   initial begin
      logic [12:0] e;
      int c0;
      rst = 1'b1;
      in_valid = 1'b0;
      in_sum = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      chk("rst_in_ready", int'(bus12.in_ready), 1);
      chk("rst_out_valid", int'(bus12.out_valid), 0);
      chk("rst_busy", int'(busy12), 0);
      chk("rst_out_acc", int'(bus12.out_acc), 0);
      chk("rst_out_ovf", int'(bus12.out_ovf), 0);

      // 8 x 31 with continuous valid
      c0 = cyc;
      repeat (8) push(5'd31);
      in_valid = 1'b0;
      chk("t1_cycles", cyc - c0, 8);
      chk("t1_out_valid", int'(bus12.out_valid), 1);
      chk("t1_out_acc", int'(bus12.out_acc), 248);
      chk("t1_in_ready_hold", int'(bus12.in_ready), 0);
      chk("t1_busy_hold", int'(busy12), 1);
      expect_frame("t1");
      chk("t1_busy_after", int'(busy12), 0);
      chk("t1_out_valid_after", int'(bus12.out_valid), 0);

      // 1..8 with a gap after every sample
      for (int i = 1; i <= 8; i++) begin
         push(5'(i));
         in_valid = 1'b0;
         tick();
      end
      expect_frame("t2");

      // consumer stalls for 5 cycles while upstream keeps poking
      out_ready = 1'b0;
      repeat (8) push(5'($urandom_range(0, 31)));
      in_valid = 1'b0;
      e = model(frame_total, 12);
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_sum = 5'($urandom_range(0, 31));
         chk("t3_out_valid", int'(bus12.out_valid), 1);
         chk("t3_out_acc_stable", int'(bus12.out_acc), int'(e[11:0]));
         chk("t3_out_ovf_stable", int'(bus12.out_ovf), int'(e[12]));
         chk("t3_in_ready", int'(bus12.in_ready), 0);
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      expect_frame("t3");
      chk("t3_out_valid_after", int'(bus12.out_valid), 0);
      chk("t3_in_ready_after", int'(bus12.in_ready), 1);
      repeat (8) push(5'($urandom_range(0, 31)));
      in_valid = 1'b0;
      expect_frame("t3_next");

      // asynchronous reset part-way through a frame
      repeat (4) push(5'($urandom_range(0, 31)));
      in_valid = 1'b0;
      #3 rst = 1'b1;
      #1;
      chk("t4_out_valid", int'(bus12.out_valid), 0);
      chk("t4_busy", int'(busy12), 0);
      chk("t4_in_ready", int'(bus12.in_ready), 1);
      chk("t4_out_acc", int'(bus12.out_acc), 0);
      chk("t4_out_ovf6", int'(bus6.out_ovf), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      frame_total = 0;
      chk("t4_no_result", res12.size() + res6.size(), 0);
      repeat (8) push(5'd2);
      in_valid = 1'b0;
      expect_frame("t4");

      // three back-to-back frames, valid never dropped
      c0 = cyc;
      for (int f = 0; f < 3; f++) begin
         repeat (8) push(5'($urandom_range(0, 31)));
         ft[f] = frame_total;
         frame_total = 0;
      end
      in_valid = 1'b0;
      chk("t5_cycles", cyc - c0, 26);
      for (int f = 0; f < 3; f++) begin
         frame_total = ft[f];
         expect_frame("t5");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
